multi_channel_scfifo: RTL and testbench
=======================================

Name: multi_channel_scfifo

Overview:
- Parametrised successor to the single-channel show-ahead FIFO wrapper. Provides CHANNELS independent single-clock show-ahead FIFOs on one clock, using inferred RAM with no vendor IP.
- Adds over the single-channel version:
  - full-range fill count
  - almost_empty with a programmable threshold
  - per-channel synchronous flush
  - sticky overflow/underflow error flags
- Used in the 8-channel Ethernet datapath for per-channel descriptor and metadata buffering.

Parameters:
- CHANNELS, 8: number of independent FIFOs.
- ADDR_WIDTH, 4: log2 depth; DEPTH = 2**ADDR_WIDTH (legal 2..12).
- DATA_WIDTH, 64: word width per channel.
- ALMOST_FULL_VALUE, 3: almost_full asserts when usedw >= DEPTH-ALMOST_FULL_VALUE.
- ALMOST_EMPTY_VALUE, 2: almost_empty asserts when usedw <= ALMOST_EMPTY_VALUE.
- RAM_BLOCK_TYPE, "MLAB": ramstyle attribute applied to the storage array ("MLAB" or "M20K").

Ports:
- clock  in  1  single clock for all channels.
- aclr_n  in  1  asynchronous active-low reset.
- sclr  in  CHANNELS  per-channel synchronous flush.
- clr_err  in  CHANNELS  per-channel clear of sticky error flags.
- wrreq  in  CHANNELS  write strobe; bit c drives channel c.
- data  in  CHANNELS*DATA_WIDTH  write data; channel c occupies [c*DATA_WIDTH +: DATA_WIDTH].
- rdreq  in  CHANNELS  read acknowledge (show-ahead pop).
- q  out  CHANNELS*DATA_WIDTH  head-of-FIFO data; valid when empty[c]=0.
- empty  out  CHANNELS  channel holds no words.
- full  out  CHANNELS  usedw == DEPTH.
- almost_full  out  CHANNELS  threshold flag.
- almost_empty  out  CHANNELS  threshold flag.
- usedw  out  CHANNELS*(ADDR_WIDTH+1)  fill count, 0..DEPTH inclusive.
- overflow  out  CHANNELS  sticky: a write was attempted while full.
- underflow  out  CHANNELS  sticky: a read was attempted while empty.

Behaviour:
- Reset (aclr_n low, asynchronous):
  - all pointers and counts go to 0.
  - empty=1, almost_empty=1, full=0, almost_full=0, usedw=0, overflow=0, underflow=0, q=0.
  - Reset deassertion is used synchronously inside the block; no operation is accepted in the first cycle after release.
- Channels are fully independent; all conditions below apply per channel c.
- Accepted write: wrreq & ~full. Accepted read: rdreq & ~empty. Both are evaluated at the rising edge.
- Write while full is dropped, storage is unchanged, overflow is set. This holds even when rdreq is high in the same cycle, because full is checked against the pre-edge state.
- Read while empty is ignored and underflow is set. This holds even when wrreq is high in the same cycle; the write is still accepted.
- Simultaneous accepted read and write: usedw is unchanged, both pointers advance, and q presents the next word.
- usedw: +1 on write only, -1 on read only, unchanged otherwise. It never wraps outside 0..DEPTH.
- Flags are all registered and consistent with usedw in the same cycle:
  - full = (usedw==DEPTH)
  - empty = (usedw==0)
  - almost_full = (usedw >= DEPTH-ALMOST_FULL_VALUE)
  - almost_empty = (usedw <= ALMOST_EMPTY_VALUE)
- Show-ahead latency:
  - A word written into an empty channel at edge t appears on q with empty=0 after edge t (one-cycle write-to-visible).
  - After an accepted read at edge t, q shows the next word after edge t.
  - Because RAM read is registered, implement this with a one-entry output register plus bypass. The output register counts toward usedw.
- q holds its last value when empty; the value is don't-care for checkers.
- Pointers are ADDR_WIDTH bits and wrap modulo DEPTH.
- sclr[c]: at the edge, channel c returns to its reset state, except that overflow/underflow are not cleared. sclr has priority over same-cycle wrreq/rdreq, which are discarded without setting error flags.
- clr_err[c] clears both sticky flags at the edge. If a new error event occurs in the same cycle, set wins.
- Error flags are monitoring only and do not stall the FIFO.

Test Plan:
1. Reset then 16 writes to ch0 (DEPTH=16) with data 0..15 → full=1 after the 16th edge, usedw=16, almost_full first asserts at usedw=13; q=0 one cycle after the first write.
2. Full ch0, pulse wrreq+rdreq together with data 0xAA → write dropped, overflow=1, usedw=15, subsequent reads return 1..15 and never 0xAA.
3. Empty ch3, pulse wrreq (0x55) + rdreq same cycle → underflow=1, usedw=1, q=0x55, empty=0 next cycle; clr_err[3] → underflow=0.
4. Half-full ch2 (usedw=8) with continuous wrreq+rdreq for 40 cycles (pointer wrap) → usedw stays 8, output stream exactly matches input order delayed by 8 words.
5. Ch5 usedw=6, assert sclr[5] with wrreq high → usedw=0, empty=1, almost_empty=1 next cycle, no overflow; other channels' usedw unchanged.
6. Drop aclr_n mid-burst on all channels → all outputs at reset values immediately (asynchronously), before the next clock edge; operation resumes correctly after release.

Source files
------------

// File: rtl/multi_channel_scfifo.sv
// multi_channel_scfifo: CHANNELS independent single-clock show-ahead FIFOs.
// Each channel keeps a RAM plus a one-word head register on q. Fill count,
// all level flags and the sticky error flags are registered per channel.
module multi_channel_scfifo #(
   parameter int CHANNELS           = 8,
   parameter int ADDR_WIDTH         = 4,
   parameter int DATA_WIDTH         = 64,
   parameter int ALMOST_FULL_VALUE  = 3,
   parameter int ALMOST_EMPTY_VALUE = 2,
   parameter     RAM_BLOCK_TYPE     = "MLAB"
) (
   input  logic                             clock,
   input  logic                             aclr_n,
   input  logic [CHANNELS-1:0]              sclr,
   input  logic [CHANNELS-1:0]              clr_err,
   input  logic [CHANNELS-1:0]              wrreq,
   input  logic [CHANNELS*DATA_WIDTH-1:0]   data,
   input  logic [CHANNELS-1:0]              rdreq,
   output logic [CHANNELS*DATA_WIDTH-1:0]   q,
   output logic [CHANNELS-1:0]              empty,
   output logic [CHANNELS-1:0]              full,
   output logic [CHANNELS-1:0]              almost_full,
   output logic [CHANNELS-1:0]              almost_empty,
   output logic [CHANNELS*(ADDR_WIDTH+1)-1:0] usedw,
   output logic [CHANNELS-1:0]              overflow,
   output logic [CHANNELS-1:0]              underflow
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0]   AF_LEVEL = (ADDR_WIDTH+1)'(DEPTH - ALMOST_FULL_VALUE);
   localparam logic [ADDR_WIDTH:0]   AE_LEVEL = (ADDR_WIDTH+1)'(ALMOST_EMPTY_VALUE);
   localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

   // Goes high one edge after reset release; gates all operations so the
   // first cycle after release accepts nothing.
   logic run_reg;

   // Registered reset release shared by all channels
   always_ff @(posedge clock or negedge aclr_n) begin
      if (!aclr_n) run_reg <= 1'b0;
      else         run_reg <= 1'b1;
   end

   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [ADDR_WIDTH-1:0] wr_ptr_reg;
      logic [ADDR_WIDTH-1:0] rd_ptr_reg;
      logic [ADDR_WIDTH-1:0] rd_ptr_inc;
      logic [ADDR_WIDTH:0]   count_reg;
      logic [ADDR_WIDTH:0]   count_next;
      logic [DATA_WIDTH-1:0] q_reg;
      logic [DATA_WIDTH-1:0] wr_word;
      logic [DATA_WIDTH-1:0] mem_word;
      logic                  empty_reg;
      logic                  full_reg;
      logic                  af_reg;
      logic                  ae_reg;
      logic                  ovf_reg;
      logic                  udf_reg;
      logic                  wr_acc;
      logic                  rd_acc;
      logic                  ovf_evt;
      logic                  udf_evt;
      logic                  head_from_data;
      logic                  head_from_mem;

      assign wr_word    = data[gi*DATA_WIDTH +: DATA_WIDTH];
      // Address of the word that follows the current head
      assign rd_ptr_inc = rd_ptr_reg + PTR_ONE;

      // Storage array; the RAM style is fixed per branch so the attribute is a literal
      if (RAM_BLOCK_TYPE == "M20K") begin : g_m20k
         (* ramstyle = "M20K" *) logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

         // RAM write port
         always_ff @(posedge clock) begin
            if (wr_acc) mem[wr_ptr_reg] <= wr_word;
         end

         assign mem_word = mem[rd_ptr_inc];
      end else begin : g_mlab
         (* ramstyle = "MLAB" *) logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

         // RAM write port
         always_ff @(posedge clock) begin
            if (wr_acc) mem[wr_ptr_reg] <= wr_word;
         end

         assign mem_word = mem[rd_ptr_inc];
      end

      // Accept/error decode against pre-edge flags and next fill count
      always_comb begin
         wr_acc  = run_reg & ~sclr[gi] & wrreq[gi] & ~full_reg;
         rd_acc  = run_reg & ~sclr[gi] & rdreq[gi] & ~empty_reg;
         ovf_evt = run_reg & ~sclr[gi] & wrreq[gi] & full_reg;
         udf_evt = run_reg & ~sclr[gi] & rdreq[gi] & empty_reg;
         count_next = count_reg;
         if (sclr[gi])
            count_next = '0;
         else if (wr_acc & ~rd_acc)
            count_next = count_reg + CNT_ONE;
         else if (rd_acc & ~wr_acc)
            count_next = count_reg - CNT_ONE;
         // New head is the incoming word when the channel holds nothing
         // behind the head; otherwise it is already in RAM behind rd_ptr.
         head_from_data = wr_acc & ((count_reg == '0) | (rd_acc & (count_reg == CNT_ONE)));
         head_from_mem  = rd_acc & (count_reg > CNT_ONE);
      end

      // Pointers, head register, fill count, flags and sticky errors
      always_ff @(posedge clock or negedge aclr_n) begin
         if (!aclr_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            q_reg      <= '0;
            empty_reg  <= 1'b1;
            full_reg   <= 1'b0;
            af_reg     <= 1'b0;
            ae_reg     <= 1'b1;
            ovf_reg    <= 1'b0;
            udf_reg    <= 1'b0;
         end else begin
            if (sclr[gi]) begin
               wr_ptr_reg <= '0;
               rd_ptr_reg <= '0;
               q_reg      <= '0;
            end else begin
               if (wr_acc) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
               if (rd_acc) rd_ptr_reg <= rd_ptr_inc;
               if (head_from_data)     q_reg <= wr_word;
               else if (head_from_mem) q_reg <= mem_word;
            end
            count_reg <= count_next;
            empty_reg <= (count_next == '0);
            full_reg  <= (count_next == DEPTH_W);
            af_reg    <= (count_next >= AF_LEVEL);
            ae_reg    <= (count_next <= AE_LEVEL);
            if (ovf_evt)          ovf_reg <= 1'b1;
            else if (clr_err[gi]) ovf_reg <= 1'b0;
            if (udf_evt)          udf_reg <= 1'b1;
            else if (clr_err[gi]) udf_reg <= 1'b0;
         end
      end

      assign q[gi*DATA_WIDTH +: DATA_WIDTH]         = q_reg;
      assign usedw[gi*(ADDR_WIDTH+1) +: ADDR_WIDTH+1] = count_reg;
      assign empty[gi]        = empty_reg;
      assign full[gi]         = full_reg;
      assign almost_full[gi]  = af_reg;
      assign almost_empty[gi] = ae_reg;
      assign overflow[gi]     = ovf_reg;
      assign underflow[gi]    = udf_reg;
   end

endmodule

// File: tb/tb_multi_channel_scfifo.sv
// Bench for multi_channel_scfifo: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based model of each channel.
module tb_multi_channel_scfifo;

   localparam int CH    = 8;
   localparam int AW    = 4;
   localparam int DW    = 64;
   localparam int DEPTH = 16;
   localparam int AFV   = 3;
   localparam int AEV   = 2;

   logic                  clock = 1'b0;
   logic                  aclr_n;
   logic [CH-1:0]         sclr;
   logic [CH-1:0]         clr_err;
   logic [CH-1:0]         wrreq;
   logic [CH-1:0]         rdreq;
   logic [CH*DW-1:0]      data;
   logic [CH*DW-1:0]      q;
   logic [CH-1:0]         empty;
   logic [CH-1:0]         full;
   logic [CH-1:0]         almost_full;
   logic [CH-1:0]         almost_empty;
   logic [CH*(AW+1)-1:0]  usedw;
   logic [CH-1:0]         overflow;
   logic [CH-1:0]         underflow;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Reference model: one queue per channel holding the words in FIFO order
   logic [DW-1:0] mq [CH][$];
   bit            m_ovf [CH];
   bit            m_udf [CH];
   bit            m_run;

   multi_channel_scfifo #(
      .CHANNELS(CH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
      .ALMOST_FULL_VALUE(AFV), .ALMOST_EMPTY_VALUE(AEV), .RAM_BLOCK_TYPE("MLAB")
   ) dut (
      .clock(clock), .aclr_n(aclr_n), .sclr(sclr), .clr_err(clr_err),
      .wrreq(wrreq), .data(data), .rdreq(rdreq), .q(q), .empty(empty),
      .full(full), .almost_full(almost_full), .almost_empty(almost_empty),
      .usedw(usedw), .overflow(overflow), .underflow(underflow)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input int c, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s ch%0d observed=%0h expected=%0h", tag, c, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < CH; c++) begin
         mq[c].delete();
         m_ovf[c] = 1'b0;
         m_udf[c] = 1'b0;
      end
      m_run = 1'b0;
   endtask

   // Apply one rising edge to the model using the currently driven inputs
   task automatic model_edge();
      int sz;
      bit ov;
      bit un;
      if (!aclr_n) return;
      if (!m_run) begin
         m_run = 1'b1;
         return;
      end
      for (int c = 0; c < CH; c++) begin
         sz = mq[c].size();
         ov = 1'b0;
         un = 1'b0;
         if (sclr[c]) begin
            mq[c].delete();
         end else begin
            ov = wrreq[c] && (sz == DEPTH);
            un = rdreq[c] && (sz == 0);
            if (rdreq[c] && sz > 0) void'(mq[c].pop_front());
            if (wrreq[c] && sz < DEPTH) mq[c].push_back(data[c*DW +: DW]);
         end
         if (ov) m_ovf[c] = 1'b1;
         else if (clr_err[c]) m_ovf[c] = 1'b0;
         if (un) m_udf[c] = 1'b1;
         else if (clr_err[c]) m_udf[c] = 1'b0;
      end
   endtask

   task automatic check_all(input bit reset_chk);
      int sz;
      for (int c = 0; c < CH; c++) begin
         sz = mq[c].size();
         chk("usedw", c, 64'(usedw[c*(AW+1) +: AW+1]), 64'(sz));
         chk("empty", c, 64'(empty[c]), 64'(sz == 0));
         chk("full", c, 64'(full[c]), 64'(sz == DEPTH));
         chk("almost_full", c, 64'(almost_full[c]), 64'(sz >= DEPTH - AFV));
         chk("almost_empty", c, 64'(almost_empty[c]), 64'(sz <= AEV));
         chk("overflow", c, 64'(overflow[c]), 64'(m_ovf[c]));
         chk("underflow", c, 64'(underflow[c]), 64'(m_udf[c]));
         if (sz > 0) chk("q", c, q[c*DW +: DW], mq[c][0]);
         if (reset_chk) chk("q_reset", c, q[c*DW +: DW], 64'd0);
      end
   endtask

   task automatic idle();
      sclr    = '0;
      clr_err = '0;
      wrreq   = '0;
      rdreq   = '0;
      data    = '0;
   endtask

   // One clock: edge, model update, check on the falling edge
   task automatic step();
      @(posedge clock);
      $display("cyc %0d rst_n=%b wr=%h rd=%h sclr=%h clr=%h", cyc, aclr_n, wrreq, rdreq, sclr, clr_err);
      model_edge();
      cyc++;
      @(negedge clock);
      check_all(1'b0);
   endtask

   task automatic rand_inputs(input int wprob, input int rprob);
      for (int c = 0; c < CH; c++) begin
         wrreq[c] = ($urandom_range(0, 99) < wprob);
         rdreq[c] = ($urandom_range(0, 99) < rprob);
         data[c*DW +: DW] = {$urandom(), $urandom()};
      end
      sclr    = ($urandom_range(0, 39) == 0) ? CH'(1 << $urandom_range(0, CH-1)) : '0;
      clr_err = ($urandom_range(0, 19) == 0) ? CH'(1 << $urandom_range(0, CH-1)) : '0;
   endtask

   initial begin
      idle();
      aclr_n = 1'b0;
      model_reset();
      repeat (3) @(negedge clock);
      check_all(1'b1);
      aclr_n = 1'b1;

      // First cycle after release: this write must be ignored
      wrreq[0] = 1'b1; data[0 +: DW] = 64'h77;
      step(); idle();

      // Fill ch0 with 0..15
      for (int i = 0; i < DEPTH; i++) begin
         wrreq[0] = 1'b1; data[0 +: DW] = 64'(i);
         step();
      end
      idle();

      // Write+read while full: write dropped, read accepted
      wrreq[0] = 1'b1; rdreq[0] = 1'b1; data[0 +: DW] = 64'hAA;
      step(); idle();
      for (int i = 0; i < DEPTH; i++) begin
         rdreq[0] = 1'b1;
         step();
      end
      idle();

      // Empty ch3: write+read together -> underflow, write accepted; then clear
      wrreq[3] = 1'b1; rdreq[3] = 1'b1; data[3*DW +: DW] = 64'h55;
      step(); idle();
      clr_err[3] = 1'b1;
      step(); idle();

      // Same-cycle error and clear on empty ch0: set wins
      rdreq[0] = 1'b1; clr_err[0] = 1'b1;
      step(); idle();

      // Ch2 half full, then 40 cycles of streaming across the pointer wrap
      for (int i = 0; i < 8; i++) begin
         wrreq[2] = 1'b1; data[2*DW +: DW] = 64'h200 + 64'(i);
         step();
      end
      idle();
      for (int i = 0; i < 40; i++) begin
         wrreq[2] = 1'b1; rdreq[2] = 1'b1; data[2*DW +: DW] = 64'h300 + 64'(i);
         step();
      end
      idle();

      // Ch5 to 6 words (ch1 alongside), then flush with write/read pending
      for (int i = 0; i < 6; i++) begin
         wrreq[5] = 1'b1; data[5*DW +: DW] = 64'h500 + 64'(i);
         wrreq[1] = 1'b1; data[1*DW +: DW] = 64'h100 + 64'(i);
         step();
      end
      idle();
      sclr[5] = 1'b1; wrreq[5] = 1'b1; rdreq[5] = 1'b1; data[5*DW +: DW] = 64'hDEAD;
      step(); idle();

      // Randomized traffic, biased toward filling then draining
      for (int i = 0; i < 150; i++) begin
         rand_inputs(70, 35);
         step();
      end
      for (int i = 0; i < 60; i++) begin
         rand_inputs(60, 55);
         step();
      end

      // Asynchronous reset mid-burst, checked before the next rising edge
      rand_inputs(80, 40);
      #2 aclr_n = 1'b0;
      #1 model_reset();
      check_all(1'b1);
      idle();
      step();
      step();
      aclr_n = 1'b1;

      for (int i = 0; i < 150; i++) begin
         rand_inputs(40, 65);
         step();
      end
      for (int i = 0; i < 100; i++) begin
         rand_inputs(75, 25);
         step();
      end
      idle();
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
